// File: rtl/pong_match_ctrl.sv
// Match-level sequencer for the pong game: start/serve/play/over and step gating.
// Optional pause support is compiled in with PONG_PAUSE_EN.
module pong_match_ctrl #(
  parameter int SERVE_FRAMES = 60,
  parameter int WIN_SCORE    = 11,
  parameter int OVER_FRAMES  = 180
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       frame_tick,
  input  logic       btn_start,
  input  logic       btn_pause,
  input  logic [2:0] sm_state,
  input  logic [3:0] score_left,
  input  logic [3:0] score_right,
  output logic       start_game,
  output logic       step_en,
  output logic       serving,
  output logic       paused,
  output logic       match_over,
  output logic [1:0] winner,
  output logic [7:0] frame_cnt
);

  localparam logic [7:0] SERVE_N = SERVE_FRAMES[7:0];
  localparam logic [7:0] OVER_N  = OVER_FRAMES[7:0];
  localparam logic [3:0] WIN_N   = WIN_SCORE[3:0];
  localparam logic [2:0] PT_OVER = 3'b101;
  localparam logic [2:0] GM_OVER = 3'b110;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SERVE = 3'd1,
    S_PLAY  = 3'd2,
    S_PAUSE = 3'd3,
    S_OVER  = 3'd4
  } state_t;

  state_t     state, state_d;
  state_t     ret_q, ret_d;
  logic [7:0] cnt_q, cnt_d;
  logic [1:0] win_q, win_d;
  logic       start_q, pause_q;
  logic       start_d;
  logic [2:0] sm_q;

  logic start_edge, pause_edge;
  logic point_edge, game_end;
  logic left_win, right_win;

  assign start_edge = btn_start & ~start_q;

`ifdef PONG_PAUSE_EN
  assign pause_edge = btn_pause & ~pause_q;
`else
  logic unused_pause;
  assign pause_edge   = 1'b0;
  assign unused_pause = btn_pause ^ pause_q;
`endif

  // point_over is acted on once, on the cycle it first appears
  assign point_edge = (sm_state == PT_OVER) &&
                      (sm_q != PT_OVER);
  assign game_end   = (sm_state == GM_OVER);
  assign left_win   = (score_left >= WIN_N);
  assign right_win  = (score_right >= WIN_N);

  always_comb begin
    state_d = state;
    ret_d   = ret_q;
    cnt_d   = cnt_q;
    win_d   = win_q;
    start_d = 1'b0;
    step_en = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (start_edge) begin
          start_d = 1'b1;
          cnt_d   = SERVE_N;
          win_d   = 2'b00;
          state_d = S_SERVE;
        end
      end
      S_SERVE: begin
        if (pause_edge) begin
          ret_d   = S_SERVE;
          state_d = S_PAUSE;
        end else if (frame_tick) begin
          if (cnt_q <= 8'd1) begin
            cnt_d   = 8'd0;
            state_d = S_PLAY;
          end else begin
            cnt_d = cnt_q - 8'd1;
          end
        end
      end
      S_PLAY: begin
        if (game_end || (point_edge &&
            (left_win || right_win))) begin
          state_d = S_OVER;
          cnt_d   = OVER_N;
          win_d   = left_win  ? 2'b01 :
                    right_win ? 2'b10 : 2'b00;
        end else if (point_edge) begin
          cnt_d   = SERVE_N;
          state_d = S_SERVE;
        end else if (pause_edge) begin
          ret_d   = S_PLAY;
          state_d = S_PAUSE;
        end else begin
          step_en = frame_tick;
        end
      end
      S_PAUSE: begin
        if (pause_edge) state_d = ret_q;
      end
      S_OVER: begin
        if (frame_tick) begin
          if (cnt_q <= 8'd1) begin
            cnt_d   = 8'd0;
            win_d   = 2'b00;
            state_d = S_IDLE;
          end else begin
            cnt_d = cnt_q - 8'd1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      ret_q      <= S_SERVE;
      cnt_q      <= 8'd0;
      win_q      <= 2'b00;
      start_q    <= 1'b0;
      pause_q    <= 1'b0;
      sm_q       <= 3'b000;
      start_game <= 1'b0;
    end else begin
      state      <= state_d;
      ret_q      <= ret_d;
      cnt_q      <= cnt_d;
      win_q      <= win_d;
      start_q    <= btn_start;
      pause_q    <= btn_pause;
      sm_q       <= sm_state;
      start_game <= start_d;
    end
  end

  assign serving    = (state == S_SERVE);
  assign match_over = (state == S_OVER);
  assign winner     = win_q;
  assign frame_cnt  = cnt_q;

`ifdef PONG_PAUSE_EN
  assign paused = (state == S_PAUSE);
`else
  assign paused = 1'b0;
`endif

endmodule

// File: tb/tb_pong_match_ctrl.sv
// Directed bench for pong_match_ctrl: serve, point, win, pause and async reset.
// Follows PONG_PAUSE_EN to pick the pause expectations.
module tb_pong_match_ctrl;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       frame_tick = 1'b0;
  logic       btn_start = 1'b0;
  logic       btn_pause = 1'b0;
  logic [2:0] sm_state = 3'b000;
  logic [3:0] score_left = 4'd0;
  logic [3:0] score_right = 4'd0;
  logic       start_game, step_en, serving;
  logic       paused, match_over;
  logic [1:0] winner;
  logic [7:0] frame_cnt;

  int n_vec = 0;
  int n_err = 0;
  int n_start = 0;
  int steps;
  int s0;
  logic se;
  logic pz;

  pong_match_ctrl dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .frame_tick (frame_tick),
    .btn_start  (btn_start),
    .btn_pause  (btn_pause),
    .sm_state   (sm_state),
    .score_left (score_left),
    .score_right(score_right),
    .start_game (start_game),
    .step_en    (step_en),
    .serving    (serving),
    .paused     (paused),
    .match_over (match_over),
    .winner     (winner),
    .frame_cnt  (frame_cnt)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (start_game) n_start++;

  task automatic chk(input string tag,
                     input int got,
                     input int exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d",
               tag, got, exp);
    end
  endtask

  task automatic frame(output logic s);
    @(negedge clk);
    frame_tick = 1'b1;
    #1 s = step_en;
    pz = pz | paused;
    @(negedge clk);
    frame_tick = 1'b0;
  endtask

  task automatic frames(input int n, output int st);
    logic s;
    st = 0;
    for (int i = 0; i < n; i++) begin
      frame(s);
      if (s) st++;
    end
  endtask

  task automatic pulse_pause();
    @(negedge clk);
    btn_pause = 1'b1;
    @(negedge clk);
    btn_pause = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    pz = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_start", start_game, 0);
    chk("rst_step", step_en, 0);
    chk("rst_serving", serving, 0);
    chk("rst_over", match_over, 0);
    chk("rst_winner", winner, 0);
    chk("rst_cnt", frame_cnt, 0);
    reset_n = 1'b1;

    // held start button gives one pulse
    s0 = n_start;
    @(negedge clk);
    btn_start = 1'b1;
    repeat (5) @(negedge clk);
    btn_start = 1'b0;
    repeat (2) @(negedge clk);
    chk("start_pulses", n_start - s0, 1);
    chk("start_serving", serving, 1);
    chk("start_cnt", frame_cnt, 60);
    chk("start_winner", winner, 0);

    frames(59, steps);
    chk("serve_cnt59", frame_cnt, 1);
    chk("serve_still", serving, 1);
    frames(1, steps);
    chk("serve_done", serving, 0);
    chk("serve_cnt0", frame_cnt, 0);
    frame(se);
    chk("play_step61", se, 1);

    // point without a winner
    score_left = 4'd3;
    score_right = 4'd2;
    @(negedge clk);
    sm_state = 3'b101;
    @(negedge clk);
    sm_state = 3'b000;
    chk("pt_serving", serving, 1);
    chk("pt_cnt", frame_cnt, 60);
    chk("pt_winner", winner, 0);
    frames(60, steps);
    chk("pt_steps", steps, 0);
    chk("pt_play", serving, 0);

    // both at WIN_SCORE with a tick: left wins, no step
    score_left = 4'd11;
    score_right = 4'd11;
    @(negedge clk);
    sm_state = 3'b101;
    frame_tick = 1'b1;
    #1 chk("win_nostep", step_en, 0);
    @(negedge clk);
    sm_state = 3'b000;
    frame_tick = 1'b0;
    chk("win_over", match_over, 1);
    chk("win_left", winner, 1);
    chk("win_cnt", frame_cnt, 180);

    s0 = n_start;
    for (int i = 1; i <= 180; i++) begin
      frame(se);
      if (i == 100) btn_start = 1'b1;
      if (i == 179) begin
        chk("over_cnt179", frame_cnt, 1);
        chk("over_held", match_over, 1);
        chk("over_win_held", winner, 1);
      end
    end
    chk("over_done", match_over, 0);
    chk("over_clr_win", winner, 0);
    chk("over_idle", serving, 0);
    repeat (3) @(negedge clk);
    chk("over_nostart", n_start - s0, 0);
    btn_start = 1'b0;
    score_left = 4'd0;
    score_right = 4'd0;

    // pause during serve at frame_cnt 30
    @(negedge clk);
    btn_start = 1'b1;
    @(negedge clk);
    btn_start = 1'b0;
    @(negedge clk);
    chk("p_serving", serving, 1);
    frames(30, steps);
    chk("p_cnt30", frame_cnt, 30);
    pz = 1'b0;
    pulse_pause();
`ifdef PONG_PAUSE_EN
    chk("p_paused", paused, 1);
    chk("p_noserve", serving, 0);
    frames(50, steps);
    chk("p_frozen", frame_cnt, 30);
    chk("p_steps", steps, 0);
    pulse_pause();
    chk("p_resume", serving, 1);
    chk("p_unpaused", paused, 0);
    chk("p_cnt_keep", frame_cnt, 30);
    frames(30, steps);
    chk("p_play", serving, 0);
    chk("p_steps2", steps, 0);
`else
    chk("np_paused", paused, 0);
    chk("np_serving", serving, 1);
    frames(50, steps);
    chk("np_steps", steps, 20);
    chk("np_cnt", frame_cnt, 0);
    chk("np_play", serving, 0);
    pulse_pause();
    chk("np_pz", pz, 0);
`endif
    frame(se);
    chk("p_step", se, 1);

    // asynchronous reset between edges in PLAY
    @(negedge clk);
    frame_tick = 1'b1;
    #1 chk("ar_step_pre", step_en, 1);
    #2 reset_n = 1'b0;
    #1;
    chk("ar_step", step_en, 0);
    chk("ar_serving", serving, 0);
    chk("ar_over", match_over, 0);
    chk("ar_paused", paused, 0);
    chk("ar_cnt", frame_cnt, 0);
    chk("ar_start", start_game, 0);
    @(negedge clk);
    frame_tick = 1'b0;
    @(negedge clk);
    s0 = n_start;
    reset_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("ar_nostart", n_start - s0, 0);
    chk("ar_idle", serving, 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
